// File: rtl/branch_resolver.sv
// branch_resolver
//   Resolves a conditional branch against a 3-bit {gt,lt,eq} flag register.
//   A request is accepted in IDLE, evaluated for exactly one cycle in EVAL and
//   held as a registered result in RESP until the consumer takes it.
//
// Ports
//   clk        clock, all state updates on its rising edge
//   rst        asynchronous active-high reset
//   flags_we   load {gt_in,lt_in,eq_in} into the flag register (any state)
//   gt_in      comparator "greater than" flag
//   lt_in      comparator "less than" flag
//   eq_in      comparator "equal" flag
//   br_valid   branch request valid
//   br_ready   resolver can accept a request (IDLE only)
//   cond       condition code (000 JMP .. 111 NOP)
//   pc         address of the branch instruction
//   offset     two's-complement branch displacement
//   res_valid  result valid (RESP)
//   res_ready  consumer accepts the result
//   taken      branch taken
//   next_pc    resolved next PC, modulo 2^WIDTH
//   flag_err   flag register was not one-hot when a flag-dependent cond was evaluated
//   flags      current flag register {gt,lt,eq}

module branch_resolver #(
    parameter int unsigned WIDTH = 18,
    parameter int unsigned OFF_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flags_we,
    input  logic             gt_in,
    input  logic             lt_in,
    input  logic             eq_in,
    input  logic             br_valid,
    output logic             br_ready,
    input  logic [2:0]       cond,
    input  logic [WIDTH-1:0] pc,
    input  logic [OFF_W-1:0] offset,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             taken,
    output logic [WIDTH-1:0] next_pc,
    output logic             flag_err,
    output logic [2:0]       flags
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             accept;

    logic [2:0]       flags_q;
    logic [2:0]       cond_q;
    logic [WIDTH-1:0] pc_q;
    logic [OFF_W-1:0] off_q;

    logic             taken_q;
    logic             flag_err_q;
    logic [WIDTH-1:0] next_pc_q;

    logic             flag_gt;
    logic             flag_lt;
    logic             flag_eq;
    logic             onehot;
    logic             cond_met;
    logic             uses_flags;
    logic             eval_err;
    logic             eval_taken;
    logic [WIDTH-1:0] off_ext;
    logic [WIDTH-1:0] eval_next_pc;

    // Flag register: writable in every state, independent of the FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q <= 3'b001;
        end else if (flags_we) begin
            flags_q <= {gt_in, lt_in, eq_in};
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        br_ready  = 1'b0;
        res_valid = 1'b0;
        case (state)
            IDLE: begin
                br_ready = 1'b1;
                if (br_valid) begin
                    accept    = 1'b1;
                    state_nxt = EVAL;
                end
            end
            EVAL: begin
                state_nxt = RESP;
            end
            RESP: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Request capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cond_q <= '0;
            pc_q   <= '0;
            off_q  <= '0;
        end else if (accept) begin
            cond_q <= cond;
            pc_q   <= pc;
            off_q  <= offset;
        end
    end

    // Evaluation uses flags_q as it stands during EVAL: a write on the accept
    // edge is already in flags_q, a write during EVAL lands only after the
    // result edge.
    always_comb begin
        flag_gt    = flags_q[2];
        flag_lt    = flags_q[1];
        flag_eq    = flags_q[0];
        onehot     = (flags_q == 3'b100) || (flags_q == 3'b010) || (flags_q == 3'b001);
        cond_met   = 1'b0;
        uses_flags = 1'b1;
        case (cond_q)
            3'b000: begin cond_met = 1'b1;              uses_flags = 1'b0; end
            3'b001: cond_met = flag_eq;
            3'b010: cond_met = ~flag_eq;
            3'b011: cond_met = flag_gt;
            3'b100: cond_met = flag_lt;
            3'b101: cond_met = flag_gt | flag_eq;
            3'b110: cond_met = flag_lt | flag_eq;
            default: begin cond_met = 1'b0;             uses_flags = 1'b0; end
        endcase
        eval_err     = uses_flags & ~onehot;
        eval_taken   = cond_met & ~eval_err;
        off_ext      = {{(WIDTH-OFF_W){off_q[OFF_W-1]}}, off_q};
        eval_next_pc = pc_q + (eval_taken ? off_ext : {{(WIDTH-1){1'b0}}, 1'b1});
    end

    // Result registers: loaded only at the end of EVAL, so they hold in RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            taken_q    <= 1'b0;
            next_pc_q  <= '0;
            flag_err_q <= 1'b0;
        end else if (state == EVAL) begin
            taken_q    <= eval_taken;
            next_pc_q  <= eval_next_pc;
            flag_err_q <= eval_err;
        end
    end

    assign taken    = taken_q;
    assign next_pc  = next_pc_q;
    assign flag_err = flag_err_q;
    assign flags    = flags_q;

endmodule

// File: tb/tb_branch_resolver.sv
module tb_branch_resolver;

    localparam int unsigned WIDTH = 18;
    localparam int unsigned OFF_W = 10;

    logic             clk = 1'b0;
    logic             rst;
    logic             flags_we;
    logic             gt_in, lt_in, eq_in;
    logic             br_valid;
    logic             br_ready;
    logic [2:0]       cond;
    logic [WIDTH-1:0] pc;
    logic [OFF_W-1:0] offset;
    logic             res_valid;
    logic             res_ready;
    logic             taken;
    logic [WIDTH-1:0] next_pc;
    logic             flag_err;
    logic [2:0]       flags;

    int errors = 0;
    int checks = 0;

    branch_resolver #(.WIDTH(WIDTH), .OFF_W(OFF_W)) dut (
        .clk(clk), .rst(rst), .flags_we(flags_we),
        .gt_in(gt_in), .lt_in(lt_in), .eq_in(eq_in),
        .br_valid(br_valid), .br_ready(br_ready),
        .cond(cond), .pc(pc), .offset(offset),
        .res_valid(res_valid), .res_ready(res_ready),
        .taken(taken), .next_pc(next_pc), .flag_err(flag_err), .flags(flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_flags(input logic [2:0] f);
        flags_we = 1'b1;
        {gt_in, lt_in, eq_in} = f;
        tick();
        flags_we = 1'b0;
    endtask

    // Issue a request and advance to RESP (accept edge + EVAL edge).
    task automatic request(input logic [2:0] c, input logic [WIDTH-1:0] p, input logic [OFF_W-1:0] o);
        br_valid = 1'b1;
        cond     = c;
        pc       = p;
        offset   = o;
        tick();
        br_valid = 1'b0;
        chk("eval_res_valid", 32'(res_valid), 32'd0);
        tick();
    endtask

    task automatic expect_result(input string tag, input logic t, input logic [WIDTH-1:0] npc, input logic err);
        chk({tag, "_valid"}, 32'(res_valid), 32'd1);
        chk({tag, "_taken"}, 32'(taken), 32'(t));
        chk({tag, "_next_pc"}, 32'(next_pc), 32'(npc));
        chk({tag, "_flag_err"}, 32'(flag_err), 32'(err));
    endtask

    task automatic consume();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("consume_res_valid", 32'(res_valid), 32'd0);
        chk("consume_br_ready", 32'(br_ready), 32'd1);
    endtask

    initial begin
        rst = 1'b1; flags_we = 1'b0; {gt_in, lt_in, eq_in} = 3'b000;
        br_valid = 1'b0; cond = 3'd0; pc = '0; offset = '0; res_ready = 1'b0;

        // Reset state
        #2;
        chk("rst_br_ready", 32'(br_ready), 32'd1);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_flags", 32'(flags), 32'h1);
        chk("rst_taken", 32'(taken), 32'd0);
        chk("rst_next_pc", 32'(next_pc), 32'd0);
        chk("rst_flag_err", 32'(flag_err), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // JE with eq set
        set_flags(3'b001);
        request(3'b001, 18'h00100, 10'h010);
        expect_result("je", 1'b1, 18'h00110, 1'b0);
        chk("resp_br_ready", 32'(br_ready), 32'd0);
        consume();

        // JB with gt set at top of address space: pc+1 wraps
        set_flags(3'b100);
        request(3'b100, 18'h3FFFF, 10'h005);
        expect_result("jb_wrap", 1'b0, 18'h00000, 1'b0);
        consume();

        // JBE with lt set, negative offset wraps below zero
        set_flags(3'b010);
        request(3'b110, 18'h00005, 10'h3F8);
        expect_result("jbe_neg", 1'b1, 18'h3FFFD, 1'b0);
        consume();

        // Non-one-hot flags
        set_flags(3'b110);
        request(3'b011, 18'h00200, 10'h020);
        expect_result("ja_bad", 1'b0, 18'h00201, 1'b1);
        consume();
        request(3'b000, 18'h00200, 10'h020);
        expect_result("jmp_bad", 1'b1, 18'h00220, 1'b0);
        consume();
        request(3'b111, 18'h00200, 10'h020);
        expect_result("nop_bad", 1'b0, 18'h00201, 1'b0);
        consume();

        // Flag write on accept edge is seen; write during EVAL is not
        br_valid = 1'b1; cond = 3'b001; pc = 18'h01000; offset = 10'h004;
        flags_we = 1'b1; {gt_in, lt_in, eq_in} = 3'b001;
        tick();
        br_valid = 1'b0;
        {gt_in, lt_in, eq_in} = 3'b010;
        tick();
        flags_we = 1'b0;
        expect_result("flag_timing", 1'b1, 18'h01004, 1'b0);
        chk("flags_after_eval_we", 32'(flags), 32'h2);
        consume();

        // Back-pressure: result held, second request ignored
        request(3'b000, 18'h00010, 10'h003);
        br_valid = 1'b1; cond = 3'b111; pc = 18'h02000; offset = 10'h001;
        for (int i = 0; i < 5; i++) begin
            expect_result("hold", 1'b1, 18'h00013, 1'b0);
            chk("hold_br_ready", 32'(br_ready), 32'd0);
            tick();
        end
        br_valid = 1'b0;
        consume();
        tick();
        chk("idle_after_consume", 32'(res_valid), 32'd0);

        // Reset mid-EVAL discards the request
        br_valid = 1'b1; cond = 3'b000; pc = 18'h00300; offset = 10'h010;
        tick();
        br_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_br_ready", 32'(br_ready), 32'd1);
        chk("rst_mid_res_valid", 32'(res_valid), 32'd0);
        chk("rst_mid_flags", 32'(flags), 32'h1);
        chk("rst_mid_next_pc", 32'(next_pc), 32'd0);
        #2 rst = 1'b0;
        tick();
        chk("post_rst_res_valid", 32'(res_valid), 32'd0);
        tick();
        chk("post_rst_res_valid2", 32'(res_valid), 32'd0);
        request(3'b010, 18'h00040, 10'h00C);
        expect_result("post_rst_jne", 1'b0, 18'h00041, 1'b0);
        consume();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
